// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and receiver state encoding (PARITY state only with UART_RX_PARITY_EN)
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY     = 3'd5
`endif
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous UART line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_sync
);

    logic [1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], rx_async};
        end
    end

    assign rx_sync = sync_ff[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART 8N1 receiver with 1-deep rts/rtr output buffer; UART_RX_PARITY_EN adds even parity
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       sop_to_uart_rtr,
    output logic       sop_to_uart_rts,
    output logic [7:0] uart_byte_out,
    output logic       framing_error,
    output logic       overrun_error
);

    localparam logic [15:0] HALF_BIT_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_BIT_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    rx_state_t   state, state_next;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        rx_s;
    logic        timer_clr;
    logic        bit_sample;
    logic        commit;
    logic        frame_err;
    logic        par_bad;
    logic        full_bit;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (rx_serial),
        .rx_sync  (rx_s)
    );

    assign full_bit = (timer == FULL_BIT_M1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        bit_sample = 1'b0;
        commit     = 1'b0;
        frame_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (!rx_s) state_next = ST_START;
            end
            ST_START: begin
                // mid-start sample rejects glitches shorter than half a bit
                if (timer == HALF_BIT_M1) begin
                    timer_clr  = 1'b1;
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_bit) begin
                    timer_clr  = 1'b1;
                    bit_sample = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_bit) begin
                    timer_clr  = 1'b1;
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_bit) begin
                    timer_clr  = 1'b1;
                    commit     = rx_s && !par_bad;
                    frame_err  = !rx_s || par_bad;
                    state_next = rx_s ? ST_IDLE : ST_BREAK_WAIT;
                end
            end
            ST_BREAK_WAIT: begin
                timer_clr = 1'b1;
                if (rx_s) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer   <= 16'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            timer <= timer_clr ? 16'd0 : timer + 16'd1;
            if (bit_sample) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {rx_s, shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // even parity: data bits plus parity bit must xor to zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_bad <= 1'b0;
        end else if (state == ST_PARITY && full_bit) begin
            par_bad <= ^{shift, rx_s};
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sop_to_uart_rts <= 1'b0;
            uart_byte_out   <= 8'h00;
            framing_error   <= 1'b0;
            overrun_error   <= 1'b0;
        end else begin
            framing_error <= frame_err;
            overrun_error <= 1'b0;
            if (commit) begin
                // a held byte that is not leaving this cycle wins over the new one
                if (sop_to_uart_rts && !sop_to_uart_rtr) begin
                    overrun_error <= 1'b1;
                end else begin
                    uart_byte_out   <= shift;
                    sop_to_uart_rts <= 1'b1;
                end
            end else if (sop_to_uart_rts && sop_to_uart_rtr) begin
                sop_to_uart_rts <= 1'b0;
            end
        end
    end

endmodule
